// File: rtl/uart_ctrl.sv
// UART controller: 16x/1x baud tick generation, RX/TX byte FIFOs, register-bus front-end,
// TX drain sequencer that hands one byte at a time to the transmitter, and a level interrupt.

module uart_ctrl #(
    parameter int unsigned BAUD_DIV = 27,
    parameter int unsigned FIFO_AW  = 4
) (
    input  logic       clock,
    input  logic       reset,
    output logic       uart_tick_16x,
    output logic       uart_tick,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_write,
    input  logic       tx_busy,
    input  logic [1:0] addr,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       irq
);

    localparam int unsigned DEPTH    = 1 << FIFO_AW;
    localparam int unsigned CW       = FIFO_AW + 1;
    localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    logic [15:0]        r_div_cnt, w_div_nxt;
    logic [3:0]         r_sub_cnt, w_sub_nxt;
    logic               r_tick_16x, r_tick;

    logic [7:0]         r_rx_mem [DEPTH];
    logic [FIFO_AW-1:0] r_rx_wp, r_rx_rp;
    logic [CW-1:0]      r_rx_cnt;
    logic [7:0]         r_tx_mem [DEPTH];
    logic [FIFO_AW-1:0] r_tx_wp, r_tx_rp;
    logic [CW-1:0]      r_tx_cnt;

    logic               r_rx_ovr, r_tx_ovf;
    logic [1:0]         r_ctrl;
    state_t             r_state, w_state_nxt;
    logic [7:0]         r_tx_data, r_rdata, w_rdata_nxt, w_status;
    logic               r_tx_write, r_ack, r_irq;

    logic w_rd, w_wr0, w_rx_nonempty, w_rx_full, w_tx_nonempty, w_tx_full, w_tx_idle;
    logic w_rx_push, w_rx_pop, w_rx_drop, w_tx_push, w_tx_pop, w_tx_drop;
    logic w_ctrl_wr, w_clr_sticky;

    assign uart_tick_16x = r_tick_16x;
    assign uart_tick     = r_tick;
    assign tx_data       = r_tx_data;
    assign tx_write      = r_tx_write;
    assign rdata         = r_rdata;
    assign ack           = r_ack;
    assign irq           = r_irq;

    // Ticks are registered, so they are decoded from the counters' next values.
    always_comb begin
        w_div_nxt = (r_div_cnt == DIV_LAST) ? 16'd0 : r_div_cnt + 16'd1;
        w_sub_nxt = r_sub_cnt + {3'b000, r_tick_16x};
    end

    // A simultaneous wr and rd is a write; only the rd-alone case reads.
    assign w_rd          = rd & ~wr;
    assign w_wr0         = wr & (addr == 2'd0);
    assign w_ctrl_wr     = wr & (addr == 2'd2);
    assign w_clr_sticky  = w_ctrl_wr & wdata[7];

    assign w_rx_nonempty = (r_rx_cnt != '0);
    assign w_rx_full     = (r_rx_cnt == CW'(DEPTH));
    assign w_tx_nonempty = (r_tx_cnt != '0);
    assign w_tx_full     = (r_tx_cnt == CW'(DEPTH));
    assign w_tx_idle     = ~w_tx_nonempty & (r_state == S_IDLE);

    assign w_rx_pop      = w_rd & (addr == 2'd0) & w_rx_nonempty;
    assign w_rx_push     = rx_ready & (~w_rx_full | w_rx_pop);
    assign w_rx_drop     = rx_ready & w_rx_full & ~w_rx_pop;
    assign w_tx_push     = w_wr0 & ~w_tx_full;
    assign w_tx_drop     = w_wr0 & w_tx_full;

    assign w_status = {2'b00, r_tx_ovf, r_rx_ovr, w_tx_full, w_tx_idle, w_rx_full, w_rx_nonempty};

    always_comb begin
        w_rdata_nxt = 8'h00;
        case (addr)
            2'd0:    w_rdata_nxt = w_rx_nonempty ? r_rx_mem[r_rx_rp] : 8'h00;
            2'd1:    w_rdata_nxt = w_status;
            2'd2:    w_rdata_nxt = {6'b000000, r_ctrl};
            default: w_rdata_nxt = 8'h00;
        endcase
    end

    // TX drain: one byte per transmitter busy cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        case (r_state)
            S_IDLE:    if (w_tx_nonempty) w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_tx_pop    = 1'b1;
                w_state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: if (tx_busy)  w_state_nxt = S_WAIT_LO;
            S_WAIT_LO: if (!tx_busy) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_data;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_sub_cnt  <= '0;
            r_tick_16x <= 1'b0;
            r_tick     <= 1'b0;
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_cnt   <= '0;
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_cnt   <= '0;
            r_rx_ovr   <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_ctrl     <= '0;
            r_state    <= S_IDLE;
            r_tx_data  <= '0;
            r_tx_write <= 1'b0;
            r_rdata    <= '0;
            r_ack      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_div_cnt  <= w_div_nxt;
            r_sub_cnt  <= w_sub_nxt;
            r_tick_16x <= (w_div_nxt == DIV_LAST);
            r_tick     <= (w_div_nxt == DIV_LAST) && (w_sub_nxt == 4'hF);

            if (w_rx_push) r_rx_wp <= r_rx_wp + FIFO_AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + FIFO_AW'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase

            if (w_tx_push) r_tx_wp <= r_tx_wp + FIFO_AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + FIFO_AW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase

            if (w_ctrl_wr) r_ctrl <= wdata[1:0];
            r_rx_ovr <= (r_rx_ovr & ~w_clr_sticky) | w_rx_drop;
            r_tx_ovf <= (r_tx_ovf & ~w_clr_sticky) | w_tx_drop;

            r_state    <= w_state_nxt;
            r_tx_write <= (w_state_nxt == S_LOAD);
            if (w_state_nxt == S_LOAD) r_tx_data <= r_tx_mem[r_tx_rp];

            r_ack <= wr | rd;
            if (w_rd) r_rdata <= w_rdata_nxt;
            r_irq <= (r_ctrl[0] & w_rx_nonempty) | (r_ctrl[1] & w_tx_idle);
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: directed scenarios plus randomized register/RX traffic checked
// against a queue-based reference model.

module tb_uart_ctrl;

    localparam int unsigned BAUD_DIV = 4;
    localparam int unsigned FIFO_AW  = 2;
    localparam int          DEPTH    = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uart_tick_16x, uart_tick;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_busy;
    logic [1:0] addr = 2'd0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       ack;
    logic       irq;

    logic busy_force = 1'b0;
    logic busy_pulse = 1'b0;
    assign tx_busy = busy_force | busy_pulse;

    uart_ctrl #(.BAUD_DIV(BAUD_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clock(clock), .reset(reset),
        .uart_tick_16x(uart_tick_16x), .uart_tick(uart_tick),
        .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_write(tx_write), .tx_busy(tx_busy),
        .addr(addr), .wr(wr), .rd(rd), .wdata(wdata),
        .rdata(rdata), .ack(ack), .irq(irq)
    );

    always #5 clock = ~clock;

    int npass  = 0;
    int ntotal = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Transmitter stand-in: every tx_write is logged, then busy goes high 2 cycles later for 10 cycles.
    logic [7:0] tx_q[$];
    int         tx_cyc[$];
    always @(negedge clock) begin
        if (tx_write) begin
            tx_q.push_back(tx_data);
            tx_cyc.push_back(cyc);
        end
    end
    initial begin
        forever begin
            @(posedge clock); #1;
            if (tx_write) begin
                repeat (2) begin @(posedge clock); #1; end
                busy_pulse = 1'b1;
                repeat (10) begin @(posedge clock); #1; end
                busy_pulse = 1'b0;
            end
        end
    end

    // Reference model of the register-visible state (TX assumed idle while it is used).
    logic [7:0] m_rxq[$];
    logic       m_rx_ovr = 1'b0;
    logic       m_tx_ovf = 1'b0;
    logic [1:0] m_ctrl = 2'b00;
    logic [7:0] m_last = 8'h00;

    function automatic logic [7:0] m_status();
        return {2'b00, m_tx_ovf, m_rx_ovr, 1'b0, 1'b1,
                m_rxq.size() == DEPTH, m_rxq.size() != 0};
    endfunction
    function automatic logic [7:0] m_pop();
        if (m_rxq.size() == 0) return 8'h00;
        return m_rxq.pop_front();
    endfunction
    function automatic void m_push(input logic [7:0] b);
        if (m_rxq.size() < DEPTH) m_rxq.push_back(b);
        else m_rx_ovr = 1'b1;
    endfunction
    function automatic logic m_irq();
        return (m_ctrl[0] && m_rxq.size() != 0) || m_ctrl[1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input logic also_rd);
        addr = a; wdata = d; wr = 1'b1; rd = also_rd;
        step();
        wr = 1'b0; rd = 1'b0;
        check("wr_ack", ack, 1);
    endtask

    task automatic read_chk(input logic [1:0] a, input logic [7:0] exp, input string tag);
        addr = a; rd = 1'b1;
        step();
        rd = 1'b0;
        check({tag, "_ack"}, ack, 1);
        check(tag, rdata, exp);
        m_last = exp;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data = b; rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_tick16"}, uart_tick_16x, 0);
        check({p, "_tick"}, uart_tick, 0);
        check({p, "_tx_data"}, tx_data, 0);
        check({p, "_tx_write"}, tx_write, 0);
        check({p, "_rdata"}, rdata, 0);
        check({p, "_ack"}, ack, 0);
        check({p, "_irq"}, irq, 0);
    endtask

    initial begin
        int         op;
        logic [7:0] b;
        logic [7:0] e;

        // Reset values, then the tick pattern with cycle 0 = first cycle out of reset.
        idle(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        for (int k = 0; k < 128; k++) begin
            check("tick16", uart_tick_16x, (k % BAUD_DIV) == (BAUD_DIV - 1));
            check("tick", uart_tick, (k % 64) == 63);
            step();
        end

        // RX ordering and empty read.
        rx_push(8'h41); rx_push(8'h42); rx_push(8'h43);
        read_chk(2'd0, 8'h41, "rx_ord0");
        read_chk(2'd0, 8'h42, "rx_ord1");
        read_chk(2'd0, 8'h43, "rx_ord2");
        read_chk(2'd0, 8'h00, "rx_empty_read");
        read_chk(2'd1, 8'h04, "rx_ord_status");

        // RX overrun, sticky clear, and push-while-full with a same-cycle pop.
        for (int i = 0; i < 5; i++) rx_push(8'hA0 + 8'(i));
        read_chk(2'd1, 8'h17, "rx_ovr_status");
        for (int i = 0; i < 4; i++) read_chk(2'd0, 8'hA0 + 8'(i), "rx_ovr_data");
        bus_write(2'd2, 8'h80, 1'b0);
        read_chk(2'd1, 8'h04, "rx_ovr_cleared");
        for (int i = 0; i < 4; i++) rx_push(8'hB0 + 8'(i));
        rx_data = 8'hB4; rx_ready = 1'b1; addr = 2'd0; rd = 1'b1;
        step();
        rx_ready = 1'b0; rd = 1'b0;
        check("full_pushpop_data", rdata, 8'hB0);
        read_chk(2'd1, 8'h07, "full_pushpop_status");
        for (int i = 1; i < 5; i++) read_chk(2'd0, 8'hB0 + 8'(i), "full_pushpop_drain");

        // TX sequencing: write-to-tx_write latency and spacing of pulses.
        tx_q.delete(); tx_cyc.delete();
        bus_write(2'd0, 8'h55, 1'b0);
        bus_write(2'd0, 8'hAA, 1'b0);
        check("tx_write_latency", tx_write, 1);
        check("tx_data_first", tx_data, 8'h55);
        for (int k = 0; k < 200 && tx_q.size() < 2; k++) step();
        idle(20);
        check("tx_pulse_count", tx_q.size(), 2);
        if (tx_q.size() == 2) begin
            check("tx_seq0", tx_q[0], 8'h55);
            check("tx_seq1", tx_q[1], 8'hAA);
            check("tx_gap_ok", (tx_cyc[1] - tx_cyc[0]) >= 12, 1);
        end
        check("tx_data_held", tx_data, 8'hAA);
        read_chk(2'd1, 8'h04, "tx_idle_after");

        // Reset while waiting on the transmitter with 3 bytes queued.
        busy_force = 1'b1;
        tx_q.delete(); tx_cyc.delete();
        for (int i = 0; i < 4; i++) bus_write(2'd0, 8'h31 + 8'(i), 1'b0);
        idle(1);
        read_chk(2'd1, 8'h00, "pre_reset_status");
        reset = 1'b1;
        step();
        check_reset_outputs("midrst");
        reset = 1'b0;
        read_chk(2'd1, 8'h04, "post_reset_status");

        // TX overflow with the transmitter held busy.
        tx_q.delete(); tx_cyc.delete();
        for (int i = 0; i < 6; i++) bus_write(2'd0, 8'h10 + 8'(i), 1'b0);
        read_chk(2'd1, 8'h28, "tx_ovf_status");
        busy_force = 1'b0;
        for (int k = 0; k < 400 && tx_q.size() < 5; k++) step();
        idle(20);
        check("tx_ovf_pulse_count", tx_q.size(), 5);
        for (int i = 0; i < 5 && i < tx_q.size(); i++) check("tx_ovf_data", tx_q[i], 8'h10 + 8'(i));
        read_chk(2'd1, 8'h24, "tx_ovf_drained");
        bus_write(2'd2, 8'h80, 1'b0);
        read_chk(2'd1, 8'h04, "tx_ovf_cleared");

        // Interrupt timing.
        bus_write(2'd2, 8'h01, 1'b0);
        idle(2);
        check("irq_rx_idle", irq, 0);
        rx_push(8'h5A);
        check("irq_rx_lag1", irq, 0);
        step();
        check("irq_rx_set", irq, 1);
        read_chk(2'd0, 8'h5A, "irq_rx_read");
        check("irq_rd_lag1", irq, 1);
        step();
        check("irq_rd_clear", irq, 0);
        bus_write(2'd2, 8'h02, 1'b0);
        check("irq_txe_lag1", irq, 0);
        step();
        check("irq_txe_set", irq, 1);
        bus_write(2'd2, 8'h80, 1'b0);
        idle(2);
        check("irq_off", irq, 0);
        read_chk(2'd3, 8'h00, "addr3_read");

        // Randomized RX/register traffic against the model.
        m_rxq.delete(); m_rx_ovr = 1'b0; m_tx_ovf = 1'b0; m_ctrl = 2'b00;
        for (int i = 0; i < 250; i++) begin
            op = int'($urandom_range(0, 7));
            b  = 8'($urandom);
            case (op)
                0, 1: begin
                    rx_push(b);
                    m_push(b);
                end
                2: begin
                    e = m_pop();
                    read_chk(2'd0, e, "rnd_rx_read");
                end
                3: read_chk(2'd1, m_status(), "rnd_status");
                4: begin
                    bus_write(2'd2, b, b[6]);
                    check("rnd_ctrl_wr_rdata_hold", rdata, m_last);
                    m_ctrl = b[1:0];
                    if (b[7]) begin m_rx_ovr = 1'b0; m_tx_ovf = 1'b0; end
                end
                5: read_chk(2'd2, {6'b000000, m_ctrl}, "rnd_ctrl_read");
                6: begin
                    bus_write(b[0] ? 2'd1 : 2'd3, b, 1'b0);
                    check("rnd_ign_wr_rdata_hold", rdata, m_last);
                end
                default: begin
                    e = m_pop();
                    m_push(b);
                    rx_data = b; rx_ready = 1'b1; addr = 2'd0; rd = 1'b1;
                    step();
                    rx_ready = 1'b0; rd = 1'b0;
                    check("rnd_pushpop_read", rdata, e);
                    m_last = e;
                end
            endcase
            step();
            check("rnd_ack_idle", ack, 0);
            check("rnd_irq", irq, m_irq());
        end
        read_chk(2'd1, m_status(), "rnd_final_status");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
